// File: rtl/raycast_column_writer.sv
// Column-height writer: streams per-column wall heights into the back
// buffer of a ping-pong pair and swaps buffers at vertical blanking.
module raycast_column_writer #(
  parameter int NUM_COLS   = 640,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 10,
  parameter int MAX_HEIGHT = 480,
  parameter int V_VISIBLE  = 480
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_height,
  input  logic [9:0]        i_vp,
  output logic              o_wen1,
  output logic [ADDR_W-1:0] o_waddr1,
  output logic [DATA_W-1:0] o_wdata1,
  output logic              o_wen2,
  output logic [ADDR_W-1:0] o_waddr2,
  output logic [DATA_W-1:0] o_wdata2,
  output logic              o_buffer_sel,
  output logic              o_swap,
  output logic              o_late
);

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_COL =
    ADDR_W'(NUM_COLS - 1);
  localparam logic [9:0] VV = 10'(V_VISIBLE);
  localparam logic [DATA_W-1:0] MAXH =
    DATA_W'(MAX_HEIGHT);

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] col;
  logic [9:0]        vp_prev;
  logic              vb_edge;
  logic              xfer;
  logic              last_col;
  logic              do_swap;
  logic [DATA_W-1:0] clamped;

  assign vb_edge  = (vp_prev != VV) && (i_vp == VV);
  assign xfer     = i_valid && o_ready;
  assign last_col = (col == LAST_COL);
  assign do_swap  = (state == WAIT_SWAP) && vb_edge;
  assign clamped  = (i_height > MAXH) ? MAXH : i_height;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FILL;
    else       state <= state_nx;
  end

  // Next state: leave FILL on the last column, return on blanking
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == FILL): begin
        if (xfer && last_col) state_nx = WAIT_SWAP;
      end
      (state == WAIT_SWAP): begin
        if (vb_edge) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Outputs decoded from state: accept beats only while filling
  always_comb begin
    o_ready = 1'b0;
    unique case (1'b1)
      (state == FILL):      o_ready = 1'b1;
      (state == WAIT_SWAP): o_ready = 1'b0;
      default:              o_ready = 1'b0;
    endcase
  end

  // Column counter wraps to 0 after the last column of a frame
  always_ff @(posedge i_clk) begin
    if (i_rst)      col <= '0;
    else if (xfer)  col <= last_col ? '0 : col + 1'b1;
  end

  // Previous vertical position for blanking-edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) vp_prev <= '0;
    else       vp_prev <= i_vp;
  end

  // Registered write into the back buffer only
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wen1   <= 1'b0;
      o_waddr1 <= '0;
      o_wdata1 <= '0;
      o_wen2   <= 1'b0;
      o_waddr2 <= '0;
      o_wdata2 <= '0;
    end else begin
      o_wen1 <= xfer && !o_buffer_sel;
      o_wen2 <= xfer && o_buffer_sel;
      if (xfer && !o_buffer_sel) begin
        o_waddr1 <= col;
        o_wdata1 <= clamped;
      end
      if (xfer && o_buffer_sel) begin
        o_waddr2 <= col;
        o_wdata2 <= clamped;
      end
    end
  end

  // Buffer select toggles with a coincident swap pulse; late is sticky
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_buffer_sel <= 1'b1;
      o_swap       <= 1'b0;
      o_late       <= 1'b0;
    end else begin
      o_swap <= do_swap;
      if (do_swap) o_buffer_sel <= ~o_buffer_sel;
      if (vb_edge && state == FILL) o_late <= 1'b1;
    end
  end

endmodule
